// File: rtl/shift_latch_pkg.sv
// rtl/shift_latch_pkg.sv - shared mode encodings and default width for shift_latch_bank
package shift_latch_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/dff_cell.sv
// rtl/dff_cell.sv - single-bit flop with synchronous reset > preset > enable priority
module dff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic P,
  input  logic EN,
  input  logic D_in,
  output logic Q,
  output logic Qbar
);

  logic q_q;

  always_ff @(posedge C) begin
    if (R) begin
      q_q <= RST_BIT;
    end else if (P) begin
      q_q <= 1'b1;
    end else if (EN) begin
      q_q <= D_in;
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;

endmodule

// File: rtl/shift_latch_bank.sv
// rtl/shift_latch_bank.sv - WIDTH-bit shift/rotate/load register with saturating shift counter
module shift_latch_bank
  import shift_latch_pkg::*;
#(
  parameter int                 WIDTH   = DEFAULT_WIDTH,
  parameter int                 CNTW    = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic              C,
  input  logic              R,
  input  logic              P,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic              ROT,
  input  logic              SIL,
  input  logic              SIR,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qbar,
  output logic              SOR,
  output logic              SOL,
  output logic [CNTW-1:0]   CNT,
  output logic              FULL
);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] qbar_w;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  // Per-bit next value; reset, preset and enable are resolved inside each cell
  always_comb begin
    q_d = q_q;
    case (MODE)
      MODE_SHR:  q_d = {(ROT ? q_q[0] : SIL), q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], (ROT ? q_q[WIDTH-1] : SIR)};
      MODE_LOAD: q_d = D;
      default:   q_d = q_q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dff_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .C    (C),
      .R    (R),
      .P    (P),
      .EN   (EN),
      .D_in (q_d[i]),
      .Q    (q_q[i]),
      .Qbar (qbar_w[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (EN) begin
      case (MODE)
        MODE_LOAD: cnt_d = '0;
        MODE_SHR, MODE_SHL: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (R || P) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = qbar_w;
  assign SOR  = q_q[0];
  assign SOL  = q_q[WIDTH-1];
  assign CNT  = cnt_q;
  assign FULL = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_shift_latch_bank.sv
// tb/tb_shift_latch_bank.sv - scoreboard bench for 8-bit and 4-bit shift_latch_bank instances
module tb_shift_latch_bank;

  typedef struct {
    logic [7:0] q;
    logic [7:0] qb;
    logic       sor;
    logic       sol;
    int         cnt;
    logic       full;
  } exp_t;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       P = 1'b0;
  logic       EN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic       ROT = 1'b0;
  logic       SIL = 1'b0;
  logic       SIR = 1'b0;
  logic [7:0] D = 8'h00;

  logic [7:0] q8, qb8;
  logic       sor8, sol8, full8;
  logic [3:0] cnt8;
  logic [3:0] q4, qb4;
  logic       sor4, sol4, full4;
  logic [2:0] cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sq[2][$];
  logic [7:0] mq[2];
  int         mc[2];
  int         mw[2];

  always #5 C = ~C;

  shift_latch_bank #(.WIDTH(8)) u8 (
    .C(C), .R(R), .P(P), .EN(EN), .MODE(MODE), .ROT(ROT), .SIL(SIL), .SIR(SIR),
    .D(D), .Q(q8), .Qbar(qb8), .SOR(sor8), .SOL(sol8), .CNT(cnt8), .FULL(full8)
  );

  shift_latch_bank #(.WIDTH(4)) u4 (
    .C(C), .R(R), .P(P), .EN(EN), .MODE(MODE), .ROT(ROT), .SIL(SIL), .SIR(SIR),
    .D(D[3:0]), .Q(q4), .Qbar(qb4), .SOR(sor4), .SOL(sol4), .CNT(cnt4), .FULL(full4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register value as plain shift/mask arithmetic, counter as min(cnt+1, width)
  task automatic step(input logic r, input logic p, input logic en, input logic [1:0] mode,
                      input logic rot, input logic sil, input logic sir, input logic [7:0] d);
    logic [7:0] mask, inb, q;
    exp_t e;
    #1;
    R = r; P = p; EN = en; MODE = mode; ROT = rot; SIL = sil; SIR = sir; D = d;
    @(posedge C);
    for (int k = 0; k < 2; k++) begin
      mask = 8'hFF >> (8 - mw[k]);
      q = mq[k];
      if (r) begin
        mq[k] = 8'h00; mc[k] = 0;
      end else if (p) begin
        mq[k] = mask; mc[k] = 0;
      end else if (en) begin
        if (mode == 2'd3) begin
          mq[k] = d & mask; mc[k] = 0;
        end else if (mode == 2'd1) begin
          inb = rot ? {7'd0, q[0]} : {7'd0, sil};
          mq[k] = ((q >> 1) | (inb << (mw[k] - 1))) & mask;
          mc[k] = (mc[k] < mw[k]) ? mc[k] + 1 : mw[k];
        end else if (mode == 2'd2) begin
          inb = rot ? {7'd0, q[mw[k]-1]} : {7'd0, sir};
          mq[k] = ((q << 1) | inb) & mask;
          mc[k] = (mc[k] < mw[k]) ? mc[k] + 1 : mw[k];
        end
      end
      e.q = mq[k];
      e.qb = ~mq[k] & mask;
      e.sor = mq[k][0];
      e.sol = mq[k][mw[k]-1];
      e.cnt = mc[k];
      e.full = (mc[k] == mw[k]);
      sq[k].push_back(e);
    end
  endtask

  always @(posedge C) begin
    exp_t e;
    #2;
    if (sq[0].size() > 0) begin
      e = sq[0].pop_front();
      chk("w8_q", {24'd0, q8}, {24'd0, e.q});
      chk("w8_qbar", {24'd0, qb8}, {24'd0, e.qb});
      chk("w8_sor", {31'd0, sor8}, {31'd0, e.sor});
      chk("w8_sol", {31'd0, sol8}, {31'd0, e.sol});
      chk("w8_cnt", {28'd0, cnt8}, e.cnt);
      chk("w8_full", {31'd0, full8}, {31'd0, e.full});
    end
    if (sq[1].size() > 0) begin
      e = sq[1].pop_front();
      chk("w4_q", {28'd0, q4}, {24'd0, e.q});
      chk("w4_qbar", {28'd0, qb4}, {24'd0, e.qb});
      chk("w4_sor", {31'd0, sor4}, {31'd0, e.sor});
      chk("w4_sol", {31'd0, sol4}, {31'd0, e.sol});
      chk("w4_cnt", {29'd0, cnt4}, e.cnt);
      chk("w4_full", {31'd0, full4}, {31'd0, e.full});
    end
  end

  initial begin
    mw[0] = 8; mw[1] = 4;
    mq[0] = 8'h00; mq[1] = 8'h00;
    mc[0] = 0; mc[1] = 0;

    // reset beats preset
    step(1, 1, 1, 2'd3, 0, 0, 0, 8'hA5);
    #2; chk("rst_q", {24'd0, q8}, 32'h00); chk("rst_qbar", {24'd0, qb8}, 32'hFF);
    step(0, 1, 1, 2'd3, 0, 0, 0, 8'hA5);
    #2; chk("preset_q", {24'd0, q8}, 32'hFF); chk("preset_cnt", {28'd0, cnt8}, 32'd0);

    // load, hold, enable low
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h96);
    repeat (3) step(0, 0, 1, 2'd0, 1, 1, 1, 8'h00);
    step(0, 0, 0, 2'd3, 0, 0, 0, 8'h00);
    #2; chk("hold_q", {24'd0, q8}, 32'h96);

    // shift right with SIL=1
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h81);
    repeat (2) step(0, 0, 1, 2'd1, 0, 1, 0, 8'h00);
    #2; chk("shr_q", {24'd0, q8}, 32'hE0); chk("shr_cnt", {28'd0, cnt8}, 32'd2);

    // rotate left to saturation
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h81);
    step(0, 0, 1, 2'd2, 1, 0, 0, 8'h00);
    #2; chk("rotl1_q", {24'd0, q8}, 32'h03);
    repeat (7) step(0, 0, 1, 2'd2, 1, 0, 0, 8'h00);
    #2; chk("rotl8_q", {24'd0, q8}, 32'h81); chk("rotl8_full", {31'd0, full8}, 32'd1);
    step(0, 0, 1, 2'd2, 1, 0, 0, 8'h00);
    #2; chk("rotl9_cnt", {28'd0, cnt8}, 32'd8);

    // shift left with SIR=0
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h01);
    repeat (7) step(0, 0, 1, 2'd2, 0, 0, 0, 8'h00);
    #2; chk("shl7_sol", {31'd0, sol8}, 32'd1);
    step(0, 0, 1, 2'd2, 0, 0, 0, 8'h00);
    #2; chk("shl8_q", {24'd0, q8}, 32'h00);

    // reset mid-shift, then resume
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h81);
    repeat (2) step(0, 0, 1, 2'd1, 0, 1, 0, 8'h00);
    step(1, 0, 1, 2'd1, 0, 1, 0, 8'h00);
    #2; chk("midrst_q", {24'd0, q8}, 32'h00); chk("midrst_cnt", {28'd0, cnt8}, 32'd0);
    step(0, 0, 1, 2'd1, 0, 1, 0, 8'h00);
    #2; chk("resume_q", {24'd0, q8}, 32'h80);

    // 4-bit instance: load A, rotate right
    step(0, 0, 1, 2'd3, 0, 0, 0, 8'h0A);
    step(0, 0, 1, 2'd1, 1, 0, 0, 8'h00);
    #2; chk("w4_rotr_q", {28'd0, q4}, 32'h5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    repeat (3) @(posedge C);
    #3;
    chk("scoreboard_drained", sq[0].size() + sq[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
